// File: rtl/lock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lock_pkg
// Brief    : Shared state encodings, digit encodings and default code for the
//            two-button lock supervisor.
// Revision : 1.0 - initial release
// ============================================================================
package lock_pkg;

    localparam int unsigned c_STATE_W = 3;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE     = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_ENTRY    = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_UNLOCKED = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_LOCKOUT  = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_PROGRAM  = 3'd4;

    localparam logic c_DIGIT_B0 = 1'b0;
    localparam logic c_DIGIT_B1 = 1'b1;

    // Wide enough for the longest supported code; the top slices it down.
    localparam int unsigned c_DEFAULT_CODE_LEN = 5;
    localparam logic [7:0]  c_DEFAULT_CODE     = 8'b0000_1011;

endpackage
`default_nettype wire

// File: rtl/lock_timer.sv
`default_nettype none
// ============================================================================
// Module   : lock_timer
// Brief    : Loadable saturating down-counter shared by UNLOCKED and LOCKOUT.
// Revision : 1.0 - initial release
// ============================================================================
module lock_timer #(
    parameter int unsigned WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Flags the edge on which the count reaches zero, so a load of N
    // yields exactly N cycles in the owning state.
    assign o_expired = (r_count <= WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : lock_supervisor
// Brief    : Attempt-based two-button lock controller with fail counting,
//            timed lockout, bounded unlock and in-field code re-programming.
// Revision : 1.0 - initial release
// ============================================================================
module lock_supervisor
    import lock_pkg::*;
#(
    parameter int unsigned          CODE_LEN       = c_DEFAULT_CODE_LEN,
    parameter logic [CODE_LEN-1:0]  DEFAULT_CODE   = c_DEFAULT_CODE[CODE_LEN-1:0],
    parameter int unsigned          MAX_FAIL       = 3,
    parameter int unsigned          UNLOCK_CYCLES  = 1000,
    parameter int unsigned          LOCKOUT_CYCLES = 5000,
    parameter int unsigned          ENTRY_TIMEOUT  = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       b0,
    input  logic       b1,
    input  logic       prog_req,
    output logic       unlock,
    output logic       locked_out,
    output logic [2:0] fail_cnt,
    output logic [2:0] state
);

    localparam int unsigned c_TIMER_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ?
                                          UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned c_TIMER_W   = $clog2(c_TIMER_MAX + 1);
    localparam int unsigned c_IDLE_W    = $clog2(ENTRY_TIMEOUT + 1);
    localparam int unsigned c_PRESS_W   = $clog2(CODE_LEN + 1);

    localparam logic [c_TIMER_W-1:0] c_UNLOCK_LOAD  = c_TIMER_W'(UNLOCK_CYCLES);
    localparam logic [c_TIMER_W-1:0] c_LOCKOUT_LOAD = c_TIMER_W'(LOCKOUT_CYCLES);
    localparam logic [c_PRESS_W-1:0] c_LAST_PRESS   = c_PRESS_W'(CODE_LEN - 1);
    localparam logic [c_IDLE_W-1:0]  c_TIMEOUT_LAST = c_IDLE_W'(ENTRY_TIMEOUT - 1);
    localparam logic [2:0]           c_MAX_FAIL     = 3'(MAX_FAIL);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next_state;

    logic [CODE_LEN-1:0]  r_entry;
    logic [CODE_LEN-1:0]  r_stage;
    logic [CODE_LEN-1:0]  r_code;
    logic [2:0]           r_fail;
    logic [c_PRESS_W-1:0] r_press_cnt;
    logic [c_IDLE_W-1:0]  r_idle_cnt;

    logic                 w_valid;
    logic                 w_digit;
    logic                 w_last_press;
    logic                 w_timeout;
    logic                 w_in_attempt;
    logic [CODE_LEN-1:0]  w_entry_shift;
    logic [CODE_LEN-1:0]  w_stage_shift;
    logic                 w_match;
    logic [2:0]           w_fail_plus;
    logic                 w_timer_expired;

    logic                 w_timer_load;
    logic [c_TIMER_W-1:0] w_timer_value;
    logic                 w_fail_inc;
    logic                 w_fail_clr;
    logic                 w_code_write;

    // A cycle with both buttons high is not a press at all.
    assign w_valid       = b0 ^ b1;
    assign w_digit       = b1 ? c_DIGIT_B1 : c_DIGIT_B0;
    assign w_last_press  = (r_press_cnt == c_LAST_PRESS);
    assign w_in_attempt  = (r_state == c_ST_ENTRY) || (r_state == c_ST_PROGRAM);
    assign w_timeout     = (r_idle_cnt == c_TIMEOUT_LAST) && !w_valid;
    assign w_entry_shift = {r_entry[CODE_LEN-2:0], w_digit};
    assign w_stage_shift = {r_stage[CODE_LEN-2:0], w_digit};
    assign w_match       = (w_entry_shift == r_code);
    assign w_fail_plus   = (r_fail == c_MAX_FAIL) ? r_fail : r_fail + 3'd1;

    lock_timer #(
        .WIDTH        (c_TIMER_W)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_timer_load),
        .i_load_value (w_timer_value),
        .o_expired    (w_timer_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_timer_load  = 1'b0;
        w_timer_value = c_UNLOCK_LOAD;
        w_fail_inc    = 1'b0;
        w_fail_clr    = 1'b0;
        w_code_write  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_valid) begin
                    w_next_state = c_ST_ENTRY;
                end
            end
            c_ST_ENTRY: begin
                if (w_valid) begin
                    if (w_last_press) begin
                        if (w_match) begin
                            w_next_state = c_ST_UNLOCKED;
                            w_timer_load = 1'b1;
                            w_fail_clr   = 1'b1;
                        end else begin
                            w_fail_inc = 1'b1;
                            if (w_fail_plus == c_MAX_FAIL) begin
                                w_next_state  = c_ST_LOCKOUT;
                                w_timer_load  = 1'b1;
                                w_timer_value = c_LOCKOUT_LOAD;
                            end else begin
                                w_next_state = c_ST_IDLE;
                            end
                        end
                    end
                end else if (w_timeout) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            c_ST_UNLOCKED: begin
                if (w_valid || w_timer_expired) begin
                    w_next_state = c_ST_IDLE;
                end else if (prog_req) begin
                    w_next_state = c_ST_PROGRAM;
                end
            end
            c_ST_LOCKOUT: begin
                if (w_timer_expired) begin
                    w_next_state = c_ST_IDLE;
                    w_fail_clr   = 1'b1;
                end
            end
            c_ST_PROGRAM: begin
                if (w_valid) begin
                    if (w_last_press) begin
                        w_next_state = c_ST_UNLOCKED;
                        w_timer_load = 1'b1;
                        w_code_write = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    always_comb begin
        unlock     = (r_state == c_ST_UNLOCKED);
        locked_out = (r_state == c_ST_LOCKOUT);
        state      = r_state;
        fail_cnt   = r_fail;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_entry     <= '0;
            r_stage     <= '0;
            r_code      <= DEFAULT_CODE;
            r_fail      <= 3'd0;
            r_press_cnt <= '0;
            r_idle_cnt  <= '0;
        end else begin
            // Stale bits from earlier attempts are shifted out after CODE_LEN presses.
            if (((r_state == c_ST_IDLE) || (r_state == c_ST_ENTRY)) && w_valid) begin
                r_entry <= w_entry_shift;
            end
            if ((r_state == c_ST_PROGRAM) && w_valid) begin
                r_stage <= w_stage_shift;
            end
            if (w_code_write) begin
                r_code <= w_stage_shift;
            end
            if (w_fail_clr) begin
                r_fail <= 3'd0;
            end else if (w_fail_inc) begin
                r_fail <= w_fail_plus;
            end
            if ((w_next_state == c_ST_ENTRY) || (w_next_state == c_ST_PROGRAM)) begin
                r_press_cnt <= r_press_cnt + c_PRESS_W'(w_valid);
            end else begin
                r_press_cnt <= '0;
            end
            if (w_in_attempt && !w_valid && !w_timeout) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end else begin
                r_idle_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : tb_lock_supervisor
// Brief    : Directed scoreboard bench for lock_supervisor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lock_supervisor;

    logic       clk;
    logic       rst;
    logic       b0;
    logic       b1;
    logic       prog_req;
    logic       unlock;
    logic       locked_out;
    logic [2:0] fail_cnt;
    logic [2:0] state;

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_ENTR = 3'd1;
    localparam logic [2:0] c_UNLK = 3'd2;
    localparam logic [2:0] c_LOCK = 3'd3;
    localparam logic [2:0] c_PROG = 3'd4;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    lock_supervisor dut (
        .clk        (clk),
        .rst        (rst),
        .b0         (b0),
        .b1         (b1),
        .prog_req   (prog_req),
        .unlock     (unlock),
        .locked_out (locked_out),
        .fail_cnt   (fail_cnt),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input string tag, input logic u, input logic l,
                            input logic [2:0] f, input logic [2:0] s);
        exp_t e;
        e.tag = tag;
        e.val = {u, l, f, s};
        sb.push_back(e);
    endtask

    task automatic observe();
        exp_t       e;
        logic [7:0] obs;
        obs = {unlock, locked_out, fail_cnt, state};
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: observed %h expected none queued", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s: observed {u,lo,fail,st}=%b expected %b", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic chk(input string tag, input logic u, input logic l,
                       input logic [2:0] f, input logic [2:0] s);
        push_exp(tag, u, l, f, s);
        observe();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic d);
        @(negedge clk);
        b0 = ~d;
        b1 = d;
        @(negedge clk);
        b0 = 1'b0;
        b1 = 1'b0;
    endtask

    task automatic press_both();
        @(negedge clk);
        b0 = 1'b1;
        b1 = 1'b1;
        @(negedge clk);
        b0 = 1'b0;
        b1 = 1'b0;
    endtask

    task automatic pulse_prog();
        @(negedge clk);
        prog_req = 1'b1;
        @(negedge clk);
        prog_req = 1'b0;
    endtask

    task automatic enter(input logic [4:0] code);
        for (int i = 4; i >= 0; i--) begin
            press(code[i]);
        end
    endtask

    initial begin
        rst      = 1'b1;
        b0       = 1'b0;
        b1       = 1'b0;
        prog_req = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(1);
        chk("reset", 1'b0, 1'b0, 3'd0, c_IDLE);

        pulse_prog();
        chk("prog_in_idle", 1'b0, 1'b0, 3'd0, c_IDLE);

        // Default code 01011, unlock exactly one cycle after the fifth press.
        press(1'b0); press(1'b1); press(1'b0); press(1'b1);
        chk("entry_4", 1'b0, 1'b0, 3'd0, c_ENTR);
        press(1'b1);
        chk("unlock_first", 1'b1, 1'b0, 3'd0, c_UNLK);
        idle(999);
        chk("unlock_last", 1'b1, 1'b0, 3'd0, c_UNLK);
        idle(1);
        chk("auto_relock", 1'b0, 1'b0, 3'd0, c_IDLE);

        // Three wrong attempts then lockout.
        enter(5'b11111);
        chk("fail_1", 1'b0, 1'b0, 3'd1, c_IDLE);
        enter(5'b11111);
        chk("fail_2", 1'b0, 1'b0, 3'd2, c_IDLE);
        enter(5'b11111);
        chk("lockout_enter", 1'b0, 1'b1, 3'd3, c_LOCK);
        press(1'b0); press(1'b1); press(1'b0); press(1'b1);
        pulse_prog();
        chk("lockout_ignore", 1'b0, 1'b1, 3'd3, c_LOCK);
        idle(4989);
        chk("lockout_last", 1'b0, 1'b1, 3'd3, c_LOCK);
        idle(1);
        chk("lockout_exit", 1'b0, 1'b0, 3'd0, c_IDLE);

        // Re-program to 10010.
        enter(5'b01011);
        chk("unlock_pre_prog", 1'b1, 1'b0, 3'd0, c_UNLK);
        pulse_prog();
        chk("program_enter", 1'b0, 1'b0, 3'd0, c_PROG);
        enter(5'b10010);
        chk("program_done", 1'b1, 1'b0, 3'd0, c_UNLK);
        press(1'b1);
        chk("manual_relock", 1'b0, 1'b0, 3'd0, c_IDLE);
        enter(5'b01011);
        chk("old_code_fails", 1'b0, 1'b0, 3'd1, c_IDLE);
        enter(5'b10010);
        chk("new_code_unlocks", 1'b1, 1'b0, 3'd0, c_UNLK);
        press(1'b0);
        chk("relock_b0", 1'b0, 1'b0, 3'd0, c_IDLE);

        // Entry timeout leaves fail_cnt untouched.
        enter(5'b11111);
        chk("fail_pre_timeout", 1'b0, 1'b0, 3'd1, c_IDLE);
        press(1'b0); press(1'b1);
        chk("partial_entry", 1'b0, 1'b0, 3'd1, c_ENTR);
        idle(1999);
        chk("timeout_edge", 1'b0, 1'b0, 3'd1, c_ENTR);
        idle(1);
        chk("timeout_abort", 1'b0, 1'b0, 3'd1, c_IDLE);

        // Both-high cycle neither shifts nor counts.
        press(1'b1); press(1'b0); press_both(); press(1'b0); press(1'b1);
        chk("both_ignored", 1'b0, 1'b0, 3'd1, c_ENTR);
        press(1'b0);
        chk("unlock_after_both", 1'b1, 1'b0, 3'd0, c_UNLK);

        // Press and prog_req together: press wins.
        @(negedge clk);
        b0 = 1'b1;
        prog_req = 1'b1;
        @(negedge clk);
        b0 = 1'b0;
        prog_req = 1'b0;
        chk("press_beats_prog", 1'b0, 1'b0, 3'd0, c_IDLE);

        // Asynchronous reset in the middle of programming.
        enter(5'b10010);
        chk("unlock_pre_rst", 1'b1, 1'b0, 3'd0, c_UNLK);
        pulse_prog();
        press(1'b1); press(1'b1); press(1'b1);
        chk("program_partial", 1'b0, 1'b0, 3'd0, c_PROG);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", 1'b0, 1'b0, 3'd0, c_IDLE);
        @(negedge clk);
        rst = 1'b0;
        enter(5'b10010);
        chk("code_reverted", 1'b0, 1'b0, 3'd1, c_IDLE);
        enter(5'b01011);
        chk("default_unlocks", 1'b1, 1'b0, 3'd0, c_UNLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lock_supervisor.md
# lock_supervisor

Supervisory controller for the two-button electronic lock. Collects b0/b1 press pulses into fixed-length attempts, compares each attempt against a programmable code register, and holds unlock for a bounded time. It also counts failed attempts, enforces a timed lockout, and lets the code be re-programmed while unlocked. It sits between the debounced keypad and the door actuator, replacing free-running sequence detection with attempt-based sequencing.

## Interface
- CODE_LEN, 5, presses per attempt (2..8)
- DEFAULT_CODE, 5'b01011, reset code; bit CODE_LEN-1 is the first press; 0 = b0, 1 = b1
- MAX_FAIL, 3, consecutive failures that trigger lockout (1..7)
- UNLOCK_CYCLES, 1000, cycles unlock stays high before auto-relock
- LOCKOUT_CYCLES, 5000, lockout duration in cycles
- ENTRY_TIMEOUT, 2000, idle cycles allowed between presses mid-attempt

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- b0  in  1  one-cycle press pulse for digit 0 (debounced upstream)
- b1  in  1  one-cycle press pulse for digit 1
- prog_req  in  1  request to re-program the code; honoured only in UNLOCKED
- unlock  out  1  actuator enable; high only in UNLOCKED
- locked_out  out  1  high only in LOCKOUT
- fail_cnt  out  3  consecutive failed attempts
- state  out  3  current FSM state encoding

## Operation
- Valid press: exactly one of b0/b1 high in a cycle. If both are high, the press is ignored entirely: no shift, no count, no timer restart.
- States: IDLE=0, ENTRY=1, UNLOCKED=2, LOCKOUT=3, PROGRAM=4. Encodings 5–7 recover to IDLE on the next edge.
- IDLE:
  - A valid press shifts into the entry register, sets press count to 1 and moves to ENTRY.
  - prog_req is ignored.
- ENTRY:
  - Each valid press shifts in and increments the press count.
  - On the CODE_LEN-th press, the shifted value is compared to the code register.
    - Match: go to UNLOCKED, clear fail_cnt, load the timer with UNLOCK_CYCLES.
    - Mismatch: increment fail_cnt. If the new value equals MAX_FAIL, go to LOCKOUT and load the timer with LOCKOUT_CYCLES; otherwise go to IDLE.
  - ENTRY_TIMEOUT cycles with no valid press: abort to IDLE. The partial entry is discarded and fail_cnt is unchanged.
- UNLOCKED:
  - Timer expiry: go to IDLE.
  - A valid press: go to IDLE immediately (manual relock). The press is not used as the first digit of a new attempt.
  - prog_req, if no press in the same cycle: go to PROGRAM with press count 0. A press in the same cycle has priority.
- PROGRAM:
  - CODE_LEN valid presses are shifted into a staging register.
  - After the last press, the staging value is written to the code register. The FSM returns to UNLOCKED with the timer reloaded to UNLOCK_CYCLES.
  - ENTRY_TIMEOUT with no press: return to IDLE and leave the code register unchanged.
- LOCKOUT:
  - All presses and prog_req are ignored.
  - Timer expiry: go to IDLE and clear fail_cnt.
- fail_cnt saturates at MAX_FAIL and is cleared only by a successful match, lockout expiry, or reset.

## Timing
- Reset (asynchronous) sets: state=IDLE, unlock=0, locked_out=0, fail_cnt=0, code register=DEFAULT_CODE, timer=0, press count=0.
- The code register is not retained across reset.
- All transitions occur on the clock edge that samples the deciding press or expiry.
- unlock, locked_out and state are decoded from the state register, so they change in the cycle after that edge: one cycle of latency from the final press to unlock=1.
- The timer is loaded with N at state entry and decremented each cycle. Expiry is when the timer reaches 0, giving exactly N cycles of unlock or locked_out.
- The entry-timeout counter restarts on every valid press and on entry to ENTRY or PROGRAM.
- When expiry and a valid press fall in the same cycle in ENTRY or PROGRAM, the press wins.
- Reset asserted mid-attempt or mid-program aborts immediately. A partially entered new code is never written.

## Structure
- Package lock_pkg holds:
  - the state enumeration constants (IDLE..PROGRAM);
  - the digit encodings (0 = b0, 1 = b1);
  - DEFAULT_CODE and the default CODE_LEN.
- One sub-module, lock_timer: a loadable down-counter with a load input, a load value and an expired output. It is sized to the maximum of UNLOCK_CYCLES and LOCKOUT_CYCLES and shared between the UNLOCKED and LOCKOUT states.
- The entry-timeout counter is a separate small counter inside the top level.

## Test plan
- Correct code: after reset, press b0,b1,b0,b1,b1 → unlock=1 exactly one cycle after the 5th press, fail_cnt=0, and unlock=0 after 1000 cycles.
- Lockout: three wrong attempts of 11111 → fail_cnt goes 1,2,3. locked_out=1 for 5000 cycles while presses are ignored. Then state=IDLE and fail_cnt=0.
- Re-program: unlock, pulse prog_req, enter 10010 → return to UNLOCKED. After relock, 01011 fails (fail_cnt=1) and 10010 unlocks.
- Timeout and simultaneous press: press 0,1 then idle 2000 cycles → IDLE with fail_cnt=0. A cycle with b0=b1=1 mid-entry → no shift and no count.
- Reset mid-program: unlock, prog_req, press 3 digits, assert rst → code is DEFAULT_CODE and all outputs are zero.
- Manual relock: in UNLOCKED, press b1 → state=IDLE next cycle, unlock=0, and press count is 0.
